// File: rtl/turn_sequencer.sv
// Two-player turn scheduler: owns tanks, angles, move budget, shot and score.
// Optional TURN_MOVE_LIMIT_EN enforces the per-turn move budget.
module turn_sequencer #(
  parameter int XW           = 4,
  parameter int AW           = 3,
  parameter int MOVE_BUDGET  = 3,
  parameter int SHOT_TIMEOUT = 31,
  parameter int WIN_SCORE    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          left_x,
  input  logic          right_x,
  input  logic          left_aim,
  input  logic          right_aim,
  input  logic          shoot,
  input  logic          new_game,
  input  logic          shot_done,
  input  logic          shot_hit,
  output logic          player,
  output logic [XW-1:0] p0_x,
  output logic [XW-1:0] p1_x,
  output logic [AW-1:0] p0_angle,
  output logic [AW-1:0] p1_angle,
  output logic [3:0]    moves_left,
  output logic          fire,
  output logic          shot_active,
  output logic [1:0]    score0,
  output logic [1:0]    score1,
  output logic          game_over,
  output logic          winner
);

  typedef enum logic [2:0] {
    IDLE, AIM, FLIGHT, RESOLVE, OVER
  } state_t;

  localparam logic [XW-1:0] X_MAX  = '1;
  localparam logic [AW-1:0] A_MAX  = '1;
  localparam logic [AW-1:0] A_MID  = AW'(1) << (AW - 1);
  localparam logic [3:0]    BUDGET = 4'(MOVE_BUDGET);
  localparam logic [7:0]    TMO    = 8'(SHOT_TIMEOUT);
  localparam logic [1:0]    WIN    = 2'(WIN_SCORE);

  state_t        state, state_d;
  logic [7:0]    timer, timer_d;
  logic          player_d;
  logic [XW-1:0] p0_x_d, p1_x_d;
  logic [AW-1:0] p0_angle_d, p1_angle_d;
  logic [3:0]    moves_left_d;
  logic          fire_d, shot_active_d;
  logic [1:0]    score0_d, score1_d;
  logic          game_over_d, winner_d;

  logic [XW-1:0] cur_x, tgt;
  logic [AW-1:0] cur_a, a_tgt;
  logic [1:0]    cur_score;
  logic          mv_req, aim_req, at_edge, collide;
  logic          budget_ok, move_ok;

  assign cur_x     = player ? p1_x : p0_x;
  assign cur_a     = player ? p1_angle : p0_angle;
  assign cur_score = player ? score1 : score0;
  assign mv_req    = left_x | right_x;
  assign aim_req   = left_aim | right_aim;

  // left_x wins over right_x when both pulse together
  assign at_edge = left_x ? (cur_x == '0) : (cur_x == X_MAX);
  assign tgt     = left_x ? cur_x - XW'(1) : cur_x + XW'(1);
  assign collide = player ? (tgt <= p0_x) : (tgt >= p1_x);

`ifdef TURN_MOVE_LIMIT_EN
  assign budget_ok = (moves_left != 4'd0);
`else
  assign budget_ok = 1'b1;
`endif

  assign move_ok = mv_req & ~at_edge & ~collide & budget_ok;

  assign a_tgt = left_aim
    ? ((cur_a == '0)    ? cur_a : cur_a - AW'(1))
    : ((cur_a == A_MAX) ? cur_a : cur_a + AW'(1));

  always_comb begin
    state_d       = state;
    timer_d       = timer;
    player_d      = player;
    p0_x_d        = p0_x;
    p1_x_d        = p1_x;
    p0_angle_d    = p0_angle;
    p1_angle_d    = p1_angle;
    moves_left_d  = moves_left;
    fire_d        = 1'b0;
    shot_active_d = shot_active;
    score0_d      = score0;
    score1_d      = score1;
    game_over_d   = game_over;
    winner_d      = winner;

    unique case (state)
      AIM: begin
        if (shoot) begin
          fire_d        = 1'b1;
          shot_active_d = 1'b1;
          timer_d       = TMO;
          state_d       = FLIGHT;
        end else if (mv_req) begin
          if (move_ok) begin
            if (player) p1_x_d = tgt;
            else        p0_x_d = tgt;
`ifdef TURN_MOVE_LIMIT_EN
            moves_left_d = moves_left - 4'd1;
`endif
          end
        end else if (aim_req) begin
          if (player) p1_angle_d = a_tgt;
          else        p0_angle_d = a_tgt;
        end
      end
      FLIGHT: begin
        if (shot_done) begin
          if (shot_hit && cur_score != 2'd3) begin
            if (player) score1_d = score1 + 2'd1;
            else        score0_d = score0 + 2'd1;
          end
          shot_active_d = 1'b0;
          state_d       = RESOLVE;
        end else if (timer == 8'd0) begin
          shot_active_d = 1'b0;
          state_d       = RESOLVE;
        end else begin
          timer_d = timer - 8'd1;
        end
      end
      RESOLVE: begin
        if (cur_score == WIN) begin
          game_over_d = 1'b1;
          winner_d    = player;
          state_d     = OVER;
        end else begin
          player_d     = ~player;
          moves_left_d = BUDGET;
          state_d      = AIM;
        end
      end
      IDLE, OVER: ;
      default: state_d = IDLE;
    endcase

    // restart reloads everything but lands in AIM
    if (new_game) begin
      state_d       = AIM;
      timer_d       = 8'd0;
      player_d      = 1'b0;
      p0_x_d        = '0;
      p1_x_d        = X_MAX;
      p0_angle_d    = A_MID;
      p1_angle_d    = A_MID;
      moves_left_d  = BUDGET;
      fire_d        = 1'b0;
      shot_active_d = 1'b0;
      score0_d      = 2'd0;
      score1_d      = 2'd0;
      game_over_d   = 1'b0;
      winner_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= 8'd0;
      player      <= 1'b0;
      p0_x        <= '0;
      p1_x        <= X_MAX;
      p0_angle    <= A_MID;
      p1_angle    <= A_MID;
      moves_left  <= BUDGET;
      fire        <= 1'b0;
      shot_active <= 1'b0;
      score0      <= 2'd0;
      score1      <= 2'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      player      <= player_d;
      p0_x        <= p0_x_d;
      p1_x        <= p1_x_d;
      p0_angle    <= p0_angle_d;
      p1_angle    <= p1_angle_d;
      moves_left  <= moves_left_d;
      fire        <= fire_d;
      shot_active <= shot_active_d;
      score0      <= score0_d;
      score1      <= score1_d;
      game_over   <= game_over_d;
      winner      <= winner_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed plan plus random pulses vs a game model.
module tb_turn_sequencer;

  localparam int XW = 4;
  localparam int AW = 3;
  localparam int MB = 3;
  localparam int TMO = 31;
  localparam int WIN = 3;
  localparam int XMAX = (1 << XW) - 1;
  localparam int AMAX = (1 << AW) - 1;
  localparam int AMID = 1 << (AW - 1);
`ifdef TURN_MOVE_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  localparam int B_LX = 0, B_RX = 1, B_LA = 2, B_RA = 3;
  localparam int B_SH = 4, B_NG = 5, B_DN = 6, B_HT = 7, B_RS = 8;
  localparam logic [8:0] NONE = 9'd0;
  localparam logic [8:0] LX = 9'd1 << B_LX;
  localparam logic [8:0] RX = 9'd1 << B_RX;
  localparam logic [8:0] RA = 9'd1 << B_RA;
  localparam logic [8:0] SH = 9'd1 << B_SH;
  localparam logic [8:0] NG = 9'd1 << B_NG;
  localparam logic [8:0] DN = 9'd1 << B_DN;
  localparam logic [8:0] HT = 9'd1 << B_HT;
  localparam logic [8:0] RS = 9'd1 << B_RS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_x = 0, right_x = 0, left_aim = 0, right_aim = 0;
  logic shoot = 0, new_game = 0, shot_done = 0, shot_hit = 0;
  logic player, fire, shot_active, game_over, winner;
  logic [XW-1:0] p0_x, p1_x;
  logic [AW-1:0] p0_angle, p1_angle;
  logic [3:0] moves_left;
  logic [1:0] score0, score1;

  always #5 clk = ~clk;

  turn_sequencer #(
    .XW(XW), .AW(AW), .MOVE_BUDGET(MB),
    .SHOT_TIMEOUT(TMO), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .reset(reset),
    .left_x(left_x), .right_x(right_x),
    .left_aim(left_aim), .right_aim(right_aim),
    .shoot(shoot), .new_game(new_game),
    .shot_done(shot_done), .shot_hit(shot_hit),
    .player(player), .p0_x(p0_x), .p1_x(p1_x),
    .p0_angle(p0_angle), .p1_angle(p1_angle),
    .moves_left(moves_left), .fire(fire),
    .shot_active(shot_active),
    .score0(score0), .score1(score1),
    .game_over(game_over), .winner(winner)
  );

  int checks = 0;
  int errors = 0;

  // game model: phase names rather than state codes
  string m_phase = "idle";
  int m_pl, m_mv, m_elapsed;
  int m_x[2], m_a[2], m_sc[2];
  int m_fire, m_act, m_over, m_win;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reload();
    m_pl = 0; m_mv = MB; m_elapsed = 0;
    m_x[0] = 0; m_x[1] = XMAX;
    m_a[0] = AMID; m_a[1] = AMID;
    m_sc[0] = 0; m_sc[1] = 0;
    m_fire = 0; m_act = 0; m_over = 0; m_win = 0;
  endtask

  task automatic m_step(input logic [8:0] v);
    int nx, na, lo, hi;
    if (v[B_RS]) begin
      m_reload(); m_phase = "idle"; return;
    end
    if (v[B_NG]) begin
      m_reload(); m_phase = "aim"; return;
    end
    m_fire = 0;
    if (m_phase == "aim") begin
      if (v[B_SH]) begin
        m_fire = 1; m_act = 1; m_elapsed = 0;
        m_phase = "flight";
      end else if (v[B_LX] || v[B_RX]) begin
        nx = m_x[m_pl] + (v[B_LX] ? -1 : 1);
        lo = (m_pl == 0) ? nx : m_x[0];
        hi = (m_pl == 1) ? nx : m_x[1];
        if (nx >= 0 && nx <= XMAX && lo < hi &&
            (!LIMIT || m_mv > 0)) begin
          m_x[m_pl] = nx;
          if (LIMIT) m_mv = m_mv - 1;
        end
      end else if (v[B_LA] || v[B_RA]) begin
        na = m_a[m_pl] + (v[B_LA] ? -1 : 1);
        if (na < 0) na = 0;
        if (na > AMAX) na = AMAX;
        m_a[m_pl] = na;
      end
    end else if (m_phase == "flight") begin
      if (v[B_DN]) begin
        if (v[B_HT] && m_sc[m_pl] < 3) m_sc[m_pl]++;
        m_act = 0; m_phase = "resolve";
      end else if (m_elapsed == TMO) begin
        m_act = 0; m_phase = "resolve";
      end else begin
        m_elapsed++;
      end
    end else if (m_phase == "resolve") begin
      if (m_sc[m_pl] == WIN) begin
        m_over = 1; m_win = m_pl; m_phase = "over";
      end else begin
        m_pl = 1 - m_pl; m_mv = MB; m_phase = "aim";
      end
    end
  endtask

  task automatic check_all();
    chk("player", int'(player), m_pl);
    chk("p0_x", int'(p0_x), m_x[0]);
    chk("p1_x", int'(p1_x), m_x[1]);
    chk("p0_angle", int'(p0_angle), m_a[0]);
    chk("p1_angle", int'(p1_angle), m_a[1]);
    chk("moves_left", int'(moves_left), m_mv);
    chk("fire", int'(fire), m_fire);
    chk("shot_active", int'(shot_active), m_act);
    chk("score0", int'(score0), m_sc[0]);
    chk("score1", int'(score1), m_sc[1]);
    chk("game_over", int'(game_over), m_over);
    if (m_over != 0) chk("winner", int'(winner), m_win);
  endtask

  task automatic cyc(input logic [8:0] v);
    left_x = v[B_LX]; right_x = v[B_RX];
    left_aim = v[B_LA]; right_aim = v[B_RA];
    shoot = v[B_SH]; new_game = v[B_NG];
    shot_done = v[B_DN]; shot_hit = v[B_HT];
    reset = v[B_RS];
    @(posedge clk);
    m_step(v);
    @(negedge clk);
    check_all();
  endtask

  task automatic miss_turn();
    cyc(SH); cyc(DN); cyc(NONE);
  endtask

  task automatic hit_turn();
    cyc(SH); cyc(DN | HT); cyc(NONE);
  endtask

  initial begin
    int n, saved_mv;
    logic [8:0] v;
    m_reload();
    @(negedge clk);
    cyc(RS);
    chk("rst_p1_x", int'(p1_x), 15);
    chk("rst_angle", int'(p0_angle), 4);
    chk("rst_moves", int'(moves_left), 3);
    chk("rst_over", int'(game_over), 0);
    cyc(RX);
    chk("idle_ignores", int'(p0_x), 0);

    cyc(NG);
    repeat (5) cyc(RX);
    chk("budget_x", int'(p0_x), LIMIT ? 3 : 5);
    chk("budget_left", int'(moves_left), LIMIT ? 0 : 3);

    n = 0;
    while (m_x[0] < 14 && n < 80) begin
      if (m_mv == 0) begin miss_turn(); miss_turn(); end
      else cyc(RX);
      n++;
    end
    if (m_mv == 0) begin miss_turn(); miss_turn(); end
    chk("drive_14", int'(p0_x), 14);
    saved_mv = m_mv;
    cyc(RX);
    chk("collide_x", int'(p0_x), 14);
    chk("collide_mv", int'(moves_left), saved_mv);
    repeat (9) cyc(RA);
    chk("aim_sat", int'(p0_angle), 7);
    miss_turn(); miss_turn();

    cyc(SH | RX);
    chk("fire_hi", int'(fire), 1);
    chk("shoot_prio", int'(p0_x), 14);
    cyc(NONE);
    chk("fire_lo", int'(fire), 0);
    cyc(DN | HT);
    cyc(NONE);
    chk("hit_score0", int'(score0), 1);
    chk("hit_player", int'(player), 1);
    chk("hit_moves", int'(moves_left), 3);

    cyc(SH);
    n = 1;
    while (shot_active && n < 40) begin
      cyc(NONE);
      if (shot_active) n++;
    end
    chk("flight_len", n, TMO + 1);
    cyc(NONE);
    chk("tmo_score1", int'(score1), 0);
    chk("tmo_player", int'(player), 0);

    hit_turn(); miss_turn(); hit_turn();
    chk("over", int'(game_over), 1);
    chk("winner", int'(winner), 0);
    repeat (6) cyc(SH | DN | HT | RX);
    chk("over_hold", int'(score0), 3);
    cyc(NG);
    chk("ng_score", int'(score0), 0);
    chk("ng_player", int'(player), 0);

    cyc(RX); cyc(SH);
    cyc(NG | DN | HT);
    chk("ng_flight_sc", int'(score0), 0);
    chk("ng_flight_x", int'(p0_x), 0);
    chk("ng_flight_act", int'(shot_active), 0);
    cyc(SH);
    chk("ng_aim_fire", int'(fire), 1);

    for (int i = 0; i < 800; i++) begin
      v = NONE;
      v[B_LX] = ($urandom_range(0, 5) == 0);
      v[B_RX] = ($urandom_range(0, 4) == 0);
      v[B_LA] = ($urandom_range(0, 5) == 0);
      v[B_RA] = ($urandom_range(0, 5) == 0);
      v[B_SH] = ($urandom_range(0, 7) == 0);
      v[B_DN] = ($urandom_range(0, 3) == 0);
      v[B_HT] = ($urandom_range(0, 1) == 0);
      v[B_NG] = ($urandom_range(0, 99) == 0);
      v[B_RS] = ($urandom_range(0, 299) == 0);
      cyc(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Two-player turn scheduler for the tank game. It sits between the one-pulse command outputs of the controls block and the projectile/physics block. It owns each player's tank position, barrel angle, per-turn move budget, shot handshake and score, and it grants the shared controls to exactly one player at a time. All outputs are registered.

## Interface
- XW, default 4: tank position width. Positions run 0..2^XW-1.
- AW, default 3: barrel angle width. Angles run 0..2^AW-1.
- MOVE_BUDGET, default 3: moves allowed per turn, range 1..15.
- SHOT_TIMEOUT, default 31: maximum wait for `shot_done`, range 1..255.
- WIN_SCORE, default 3: score that ends the game, range 1..3.

- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- left_x, right_x  in  1 each  single-cycle move pulses.
- left_aim, right_aim  in  1 each  single-cycle aim pulses.
- shoot  in  1  single-cycle fire pulse.
- new_game  in  1  level or pulse; restarts the game.
- shot_done  in  1  physics reports the projectile is resolved.
- shot_hit  in  1  qualifies `shot_done`: 1 = hit opponent.
- player  out  1  player whose turn it is (0/1).
- p0_x, p1_x  out  XW each  tank positions.
- p0_angle, p1_angle  out  AW each  barrel angles.
- moves_left  out  4  remaining move budget for the current turn.
- fire  out  1  one-cycle launch strobe to physics.
- shot_active  out  1  high while in FLIGHT.
- score0, score1  out  2 each  player scores.
- game_over  out  1  high in OVER.
- winner  out  1  valid while `game_over` = 1.

## Operation
- States: IDLE, AIM, FLIGHT, RESOLVE, OVER. State is held in registers.
- Reset values:
  - state IDLE; player 0.
  - p0_x 0; p1_x 2^XW-1.
  - Both angles 2^(AW-1).
  - moves_left MOVE_BUDGET.
  - fire 0, shot_active 0.
  - Scores 0; game_over 0; winner 0.
- `new_game` high in any state reloads all reset values except state, and enters AIM. No `fire` is issued. It has priority over every other input that cycle.
- IDLE: all command pulses are ignored.
- AIM: the current player's tank and angle are the only ones affected. Per-cycle priority is shoot > move > aim. Lower-priority pulses in the same cycle are dropped.
  - `left_x`: x-1. `right_x`: x+1.
  - A move is blocked if it would leave 0..2^XW-1, would make p0_x >= p1_x, or moves_left = 0.
  - A blocked move changes nothing and does not consume budget. A legal move decrements moves_left.
  - `left_aim`: angle-1, saturating at 0. `right_aim`: angle+1, saturating at 2^AW-1. Aim never consumes budget.
  - `shoot`: `fire` = 1 for exactly one cycle. Load the timer with SHOT_TIMEOUT and enter FLIGHT.
- FLIGHT: `shot_active` = 1 and all command pulses are ignored.
  - `shot_done`=1 with `shot_hit`=1: increment the current player's score, saturating at 3. Go to RESOLVE.
  - `shot_done`=1 with `shot_hit`=0: go to RESOLVE.
  - Otherwise the timer decrements. If the timer is 0 with no `shot_done`, the shot counts as a miss and the block goes to RESOLVE.
  - If `shot_done` and timeout coincide, `shot_done` wins.
- `shot_done` outside FLIGHT is ignored.
- RESOLVE (one cycle):
  - If the current player's score = WIN_SCORE: go to OVER, winner = player, game_over = 1.
  - Otherwise toggle player, reload moves_left = MOVE_BUDGET, and go to AIM.
- OVER: holds all outputs. Only `new_game` or `reset` leaves OVER.
- `reset` overrides `new_game` and returns the block to IDLE.

## Timing
- Inputs are sampled on the rising edge of `clk`. An input in cycle n is reflected on outputs in cycle n+1.
- `fire` rises in the cycle after `shoot` is sampled. `shot_active` rises in the same cycle as `fire`.
- FLIGHT lasts 1 to SHOT_TIMEOUT+1 cycles. RESOLVE always lasts exactly 1 cycle.
- Turn handover: the `player` toggle is visible 1 cycle after leaving FLIGHT.
- The earliest legal `shot_done` is the first FLIGHT cycle, i.e. the same cycle `fire` is high.

## Configuration
- `TURN_MOVE_LIMIT_EN` defined:
  - The move budget is enforced as described.
  - `moves_left` counts down from MOVE_BUDGET.
- `TURN_MOVE_LIMIT_EN` undefined:
  - The budget check is removed and moves are limited only by range and collision.
  - `moves_left` is tied to MOVE_BUDGET and never decrements.

## Test plan
- Reset, then `new_game`, then 5× `right_x` (MOVE_BUDGET=3, macro defined) -> p0_x=3, moves_left=0. The 4th and 5th pulses are ignored.
- Drive player 0 to p0_x=14 with p1_x=15, then `right_x` -> blocked; p0_x stays 14 and moves_left is unchanged. 9× `right_aim` -> p0_angle saturates at 7.
- `shoot` -> `fire` high for 1 cycle, next cycle. Then `shot_done`=1, `shot_hit`=1 two cycles later -> score0=1, player=1, moves_left=3.
- `shoot` with no `shot_done` (SHOT_TIMEOUT=31) -> FLIGHT exits after 32 cycles as a miss; score unchanged; player toggles.
- Player 0 hits three times (WIN_SCORE=3) -> game_over=1, winner=0. Further pulses are ignored. `new_game` -> scores 0, AIM, player 0.
- `new_game` asserted during FLIGHT, coincident with `shot_done`/`shot_hit` -> no score change; state AIM; positions, angles and scores at reset values.
